ysyx_22041207_mul_iter: RTL and testbench

Parametrised iterative multi-cycle multiplier: the next generation of the core's shift-add multiplier unit, sitting beside the ALU in the EX stage. It adds configurable operand width and bits retired per cycle (radix). It supports per-operand signedness for MUL/MULH/MULHSU/MULHU, and holds the result until the consumer takes it via an `out_valid`/`out_ready` handshake. Pipeline flush aborts an operation in flight.

---
 rtl/ysyx_22041207_mul_iter.sv | 170 +++++++++++++++++
 tb/tb_ysyx_22041207_mul_iter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_mul_iter.sv
// ysyx_22041207_mul_iter: iterative shift-add multiplier for the EX stage.
// Retires STEP multiplier bits per cycle on operand magnitudes, then applies
// the product sign in a single FIX cycle. The result is held until the
// consumer takes it with out_valid/out_ready. A flush aborts the operation
// in flight.
//
// Ports:
//   clk, rst (async, active-low)
//   mul_valid, mul_signed[1:0] ({A signed, B signed}), multiplicand, multiplier
//   flush      - abort the current operation (ignored in IDLE, blocks accept)
//   out_ready  - consumer takes the result
//   mul_ready  - unit idle and able to accept (registered)
//   out_valid  - result valid (registered)
//   result_hi/result_lo - product bits [2W-1:W] / [W-1:0] (registered)
//
// Optional build macro YSYX_22041207_MUL_EARLY_OUT_EN: leave CALC as soon as
// the remaining multiplier magnitude is zero. Results are unchanged; only
// latency shrinks.
module ysyx_22041207_mul_iter #(
   parameter int unsigned W    = 64,
   parameter int unsigned STEP = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mul_valid,
   input  logic [1:0]   mul_signed,
   input  logic [W-1:0] multiplicand,
   input  logic [W-1:0] multiplier,
   input  logic         flush,
   input  logic         out_ready,
   output logic         mul_ready,
   output logic         out_valid,
   output logic [W-1:0] result_hi,
   output logic [W-1:0] result_lo
);

   localparam int unsigned N  = W / STEP;
   localparam int unsigned PW = 2 * W;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   a_shift_q, a_shift_d;
   logic [W-1:0]    b_mag_q, b_mag_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            neg_q, neg_d;
   logic            mul_ready_q, mul_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    res_hi_q, res_hi_d;
   logic [W-1:0]    res_lo_q, res_lo_d;

   logic            a_neg, b_neg;
   logic [W-1:0]    a_mag, b_mag;
   logic [PW-1:0]   pp;
   logic [PW-1:0]   prod;

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      a_shift_d   = a_shift_q;
      b_mag_d     = b_mag_q;
      cnt_d       = cnt_q;
      neg_d       = neg_q;
      out_valid_d = out_valid_q;
      res_hi_d    = res_hi_q;
      res_lo_d    = res_lo_q;

      // Magnitudes of the incoming operands; the most negative value maps
      // to 2^(W-1), which is its correct unsigned magnitude.
      a_neg = mul_signed[1] & multiplicand[W-1];
      b_neg = mul_signed[0] & multiplier[W-1];
      a_mag = a_neg ? -multiplicand : multiplicand;
      b_mag = b_neg ? -multiplier   : multiplier;

      // STEP-bit slice of the multiplier times the shifted multiplicand
      pp = '0;
      for (int i = 0; i < int'(STEP); i++) begin
         if (b_mag_q[i]) pp = pp + (a_shift_q << i);
      end

      prod = neg_q ? -acc_q : acc_q;

      case (state_q)
         S_IDLE: begin
            if (mul_valid && !flush) begin
               state_d   = S_CALC;
               a_shift_d = PW'(a_mag);
               b_mag_d   = b_mag;
               neg_d     = a_neg ^ b_neg;
               acc_d     = '0;
               cnt_d     = '0;
            end
         end
         S_CALC: begin
            acc_d     = acc_q + pp;
            a_shift_d = a_shift_q << STEP;
            b_mag_d   = b_mag_q >> STEP;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) state_d = S_FIX;
`ifdef YSYX_22041207_MUL_EARLY_OUT_EN
            if (b_mag_d == '0) state_d = S_FIX;
`endif
         end
         S_FIX: begin
            res_hi_d    = prod[PW-1:W];
            res_lo_d    = prod[W-1:0];
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flush aborts without touching the held result
      if (flush && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         res_hi_d    = res_hi_q;
         res_lo_d    = res_lo_q;
      end

      mul_ready_d = (state_d == S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         a_shift_q   <= '0;
         b_mag_q     <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         mul_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         res_hi_q    <= '0;
         res_lo_q    <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         a_shift_q   <= a_shift_d;
         b_mag_q     <= b_mag_d;
         cnt_q       <= cnt_d;
         neg_q       <= neg_d;
         mul_ready_q <= mul_ready_d;
         out_valid_q <= out_valid_d;
         res_hi_q    <= res_hi_d;
         res_lo_q    <= res_lo_d;
      end
   end

   assign mul_ready = mul_ready_q;
   assign out_valid = out_valid_q;
   assign result_hi = res_hi_q;
   assign result_lo = res_lo_q;

endmodule

// File: tb/tb_ysyx_22041207_mul_iter.sv
// Self-checking bench for ysyx_22041207_mul_iter: a W=64/STEP=1 instance and
// a W=32/STEP=4 instance, checked against a scoreboard of reference products.
module tb_ysyx_22041207_mul_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   // W=64, STEP=1 instance
   logic        mul_valid, flush, out_ready, mul_ready, out_valid;
   logic [1:0]  mul_signed;
   logic [63:0] multiplicand, multiplier, result_hi, result_lo;

   // W=32, STEP=4 instance
   logic        mv2, fl2, ordy2, rdy2, ov2;
   logic [1:0]  sg2;
   logic [31:0] a2, b2, hi2, lo2;

   int n_checks = 0;
   int n_fail   = 0;
   logic [127:0] exp_q[$];

   ysyx_22041207_mul_iter #(.W(64), .STEP(1)) u_dut (
      .clk(clk), .rst(rst), .mul_valid(mul_valid), .mul_signed(mul_signed),
      .multiplicand(multiplicand), .multiplier(multiplier), .flush(flush),
      .out_ready(out_ready), .mul_ready(mul_ready), .out_valid(out_valid),
      .result_hi(result_hi), .result_lo(result_lo)
   );

   ysyx_22041207_mul_iter #(.W(32), .STEP(4)) u_dut32 (
      .clk(clk), .rst(rst), .mul_valid(mv2), .mul_signed(sg2),
      .multiplicand(a2), .multiplier(b2), .flush(fl2),
      .out_ready(ordy2), .mul_ready(rdy2), .out_valid(ov2),
      .result_hi(hi2), .result_lo(lo2)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference product: sign/zero-extend to 128 bits, multiply, keep 2w bits
   function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] sg, input int unsigned w);
      logic [127:0] mask, ea, eb, p, pmask;
      mask  = (128'd1 << w) - 128'd1;
      ea    = 128'(a) & mask;
      eb    = 128'(b) & mask;
      if (sg[1] && a[w-1]) ea = ea | ~mask;
      if (sg[0] && b[w-1]) eb = eb | ~mask;
      p     = ea * eb;
      pmask = (128'd1 << (2 * w)) - 128'd1;
      if (2 * w >= 128) pmask = '1;
      return p & pmask;
   endfunction

   // Accept-to-out_valid latency in cycles
   function automatic int exp_lat(input logic [63:0] b, input logic sgb,
                                  input int unsigned w, input int unsigned step);
      int bl;
      int steps;
      logic [63:0] mask, m;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      m    = b & mask;
      if (sgb && m[w-1]) m = (-m) & mask;
      bl = 0;
      for (int i = 0; i < int'(w); i++) if (m[i]) bl = i + 1;
`ifdef YSYX_22041207_MUL_EARLY_OUT_EN
      steps = (bl + int'(step) - 1) / int'(step);
      if (steps < 1) steps = 1;
`else
      steps = int'(w / step);
`endif
      return steps + 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] sg, input int hold);
      int t;
      int lat;
      bit ready_low;
      logic [127:0] snap, e;
      t = 0;
      while (!mul_ready && t < 200) begin tick(); t++; end
      check_eq("ready_before_accept", 128'(mul_ready), 128'd1);
      mul_valid = 1'b1; multiplicand = a; multiplier = b; mul_signed = sg;
      exp_q.push_back(model(a, b, sg, 64));
      tick();
      mul_valid = 1'b0;
      lat = 0; ready_low = 1'b1;
      while (!out_valid && lat < 200) begin
         if (mul_ready) ready_low = 1'b0;
         tick(); lat++;
      end
      check_eq("latency", 128'(lat), 128'(exp_lat(b, sg[0], 64, 1)));
      check_eq("ready_low_busy", 128'(ready_low), 128'd1);
      snap = {result_hi, result_lo};
      for (int i = 0; i < hold; i++) begin
         check_eq("hold_valid", 128'(out_valid), 128'd1);
         check_eq("hold_result", {result_hi, result_lo}, snap);
         check_eq("hold_ready_low", 128'(mul_ready), 128'd0);
         tick();
      end
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check_eq("product", {result_hi, result_lo}, e);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("valid_drop", 128'(out_valid), 128'd0);
      check_eq("ready_back", 128'(mul_ready), 128'd1);
   endtask

   task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sg);
      int lat;
      logic [127:0] e;
      mv2 = 1'b1; a2 = a; b2 = b; sg2 = sg;
      exp_q.push_back(model(64'(a), 64'(b), sg, 32));
      tick();
      mv2 = 1'b0;
      lat = 0;
      while (!ov2 && lat < 100) begin tick(); lat++; end
      check_eq("latency32", 128'(lat), 128'(exp_lat(64'(b), sg[0], 32, 4)));
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check_eq("product32", 128'({hi2, lo2}), e);
      ordy2 = 1'b1;
      tick();
      ordy2 = 1'b0;
      check_eq("valid_drop32", 128'(ov2), 128'd0);
      check_eq("ready_back32", 128'(rdy2), 128'd1);
   endtask

   initial begin
      bit seen;
      logic [127:0] snap;
      rst = 1'b0;
      mul_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; mul_signed = 2'b00;
      multiplicand = '0; multiplier = '0;
      mv2 = 1'b0; fl2 = 1'b0; ordy2 = 1'b0; sg2 = 2'b00; a2 = '0; b2 = '0;
      #12;
      check_eq("rst_ready", 128'(mul_ready), 128'd1);
      check_eq("rst_valid", 128'(out_valid), 128'd0);
      check_eq("rst_result", {result_hi, result_lo}, 128'd0);
      #5 rst = 1'b1;
      tick();

      run_op(64'd3, 64'd5, 2'b00, 0);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 0);
      run_op(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 5);
      run_op(64'h1234_5678_9ABC_DEF0, 64'd1, 2'b00, 0);
      run_op(64'd3, 64'h8000_0000_0000_0000, 2'b00, 0);
      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1);
      for (int i = 0; i < 3; i++) begin
         logic [1:0] sg;
         sg = (i == 0) ? 2'b00 : ((i == 1) ? 2'b11 : 2'b10);
         run_op({$urandom, $urandom}, {$urandom, $urandom}, sg, 0);
      end

      // Flush in IDLE blocks acceptance
      flush = 1'b1; mul_valid = 1'b1; multiplicand = 64'd9; multiplier = 64'd9;
      tick();
      flush = 1'b0; mul_valid = 1'b0;
      tick();
      check_eq("idle_flush_no_accept", 128'(mul_ready), 128'd1);

      // Flush on the 10th CALC cycle
      snap = {result_hi, result_lo};
      mul_valid = 1'b1; multiplicand = 64'd11; multiplier = 64'd13; mul_signed = 2'b00;
      exp_q.push_back(model(64'd11, 64'd13, 2'b00, 64));
      tick();
      mul_valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("flush_valid", 128'(out_valid), 128'd0);
      check_eq("flush_ready", 128'(mul_ready), 128'd1);
      check_eq("flush_q_depth", 128'(exp_q.size()), 128'd1);
      void'(exp_q.pop_front());
      seen = 1'b0;
      repeat (70) begin if (out_valid) seen = 1'b1; tick(); end
      check_eq("flush_no_result", 128'(seen), 128'd0);
      check_eq("flush_result_kept", {result_hi, result_lo}, snap);

      run_op(64'd7, 64'd6, 2'b00, 0);

      // Asynchronous reset mid-CALC
      mul_valid = 1'b1; multiplicand = 64'd5; multiplier = 64'hFFFF_0000_0000_0001;
      exp_q.push_back(model(64'd5, 64'hFFFF_0000_0000_0001, 2'b00, 64));
      tick();
      mul_valid = 1'b0;
      repeat (20) tick();
      #2 rst = 1'b0;
      #1;
      check_eq("arst_valid", 128'(out_valid), 128'd0);
      check_eq("arst_ready", 128'(mul_ready), 128'd1);
      check_eq("arst_result", {result_hi, result_lo}, 128'd0);
      exp_q.delete();
      #3 rst = 1'b1;
      seen = 1'b0;
      repeat (80) begin if (out_valid) seen = 1'b1; tick(); end
      check_eq("arst_no_stale", 128'(seen), 128'd0);

      // W=32, STEP=4 instance
      run_op32(32'hFFFF_FFFF, 32'd2, 2'b00);
      run_op32(32'hFFFF_FFFD, 32'd5, 2'b11);
      run_op32($urandom, $urandom, 2'b10);
      run_op32(32'h8000_0000, 32'h8000_0000, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
